// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory program loader and the
// fetch/control datapath that reads the same 1024x16 block RAM.
//   IMEM_ADDR_W  : RAM address width (depth 2**IMEM_ADDR_W)
//   IMEM_BYTE_W  : width of one byte of the load stream
//   IMEM_DATA_W  : RAM word width (two stream bytes)
//   imem_state_t : loader FSM state encoding
package imem_pkg;

    localparam int IMEM_ADDR_W = 10;
    localparam int IMEM_BYTE_W = 8;
    localparam int IMEM_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HI    = 3'd1,
        ST_LO    = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } imem_state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Packs two stream bytes into one RAM word, high byte first.
// The high byte is held in a register; the low byte is taken straight from
// the stream so the full word is available in the cycle the low byte is
// accepted.
//   clock    : rising-edge clock
//   reset    : asynchronous active-low reset, clears the held byte
//   clear    : synchronous clear (load aborted), drops a partial word
//   load_hi  : capture in_byte as the high byte this cycle
//   in_byte  : stream byte
//   word     : {held high byte, in_byte}
module imem_word_packer #(
    parameter int BYTE_W = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic                load_hi,
    input  logic [BYTE_W-1:0]   in_byte,
    output logic [2*BYTE_W-1:0] word
);

    logic [BYTE_W-1:0] hi_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
        end else if (clear) begin
            hi_q <= '0;
        end else if (load_hi) begin
            hi_q <= in_byte;
        end
    end

    assign word = {hi_q, in_byte};

endmodule

// File: rtl/imem_program_loader.sv
// Write side of the instruction block RAM. Takes a byte stream on a
// valid/ready handshake, packs byte pairs into words (high byte first) and
// writes them to consecutive addresses starting at base_addr, holding the
// processor while the load runs.
//
// Handshake: a byte transfers on a rising edge where in_valid and in_ready
// are both 1. in_ready depends only on the registered state, so it is stable
// for the whole cycle; in_valid may be dropped at any time and the loader
// simply waits.
//
//   clock, reset : clock, asynchronous active-low reset
//   start, abort : one-cycle load request / synchronous cancel
//   base_addr    : first RAM address written
//   word_count   : words to load, 0..2**ADDR_W
//   in_byte, in_valid, in_ready : byte stream
//   addra, dina, wea            : RAM write port (registered)
//   busy, cpu_hold              : load in progress / processor stall
//   done, err                   : one-cycle pulses: completed / start rejected
//   dbg_state                   : current FSM state
module imem_program_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int BYTE_W = IMEM_BYTE_W,
    parameter int DATA_W = IMEM_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic [BYTE_W-1:0] in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic              wea,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output imem_state_t       dbg_state
);

    localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_COUNT = {{ADDR_W{1'b0}}, 1'b1};

    imem_state_t       state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   rem;
    logic [DATA_W-1:0] packed_word;
    logic              take_hi;

    assign take_hi = (state == ST_HI) && in_valid && !abort;

    imem_word_packer #(
        .BYTE_W (BYTE_W)
    ) u_packer (
        .clock   (clock),
        .reset   (reset),
        .clear   (abort),
        .load_hi (take_hi),
        .in_byte (in_byte),
        .word    (packed_word)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            addr  <= '0;
            rem   <= '0;
            addra <= '0;
            dina  <= '0;
            wea   <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            wea  <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // abort in the same cycle cancels the request outright
                    if (start && !abort) begin
                        if (word_count == '0) begin
                            done <= 1'b1;
                        end else if (word_count > MAX_COUNT) begin
                            err <= 1'b1;
                        end else begin
                            addr  <= base_addr;
                            rem   <= word_count;
                            state <= ST_HI;
                        end
                    end
                end
                ST_HI: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (in_valid) begin
                        state <= ST_LO;
                    end
                end
                ST_LO: begin
                    // The RAM write is launched here so wea/addra/dina are
                    // registered and valid for exactly the WRITE cycle.
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (in_valid) begin
                        wea   <= 1'b1;
                        addra <= addr;
                        dina  <= packed_word;
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // The word presented this cycle is already committed;
                    // an abort here only stops further words and the done.
                    if (abort) begin
                        state <= ST_IDLE;
                    end else begin
                        addr <= addr + 1'b1;
                        rem  <= rem - ONE_COUNT;
                        if (rem == ONE_COUNT) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            state <= ST_HI;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == ST_HI) || (state == ST_LO);
    assign busy      = (state != ST_IDLE);
    assign cpu_hold  = busy;
    assign dbg_state = state;

endmodule
